// File: rtl/cc_line_fill_engine.sv
// Cache line fill engine: pops miss addresses, gathers an AXI R burst (critical word
// first) into a line buffer and issues one SRAM write of {valid,tag} plus line data.
module cc_line_fill_engine #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = 8,
    parameter int INDEX_W    = 9,
    localparam int LINE_W    = LINE_BEATS * BEAT_W,
    localparam int PTR_W     = $clog2(LINE_BEATS),
    localparam int BOFS_W    = $clog2(BEAT_W / 8),
    localparam int OFS_W     = PTR_W + BOFS_W,
    localparam int TAG_W     = ADDR_W - INDEX_W - OFS_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BEAT_W-1:0]   mem_rdata_i,
    input  logic [1:0]          mem_rresp_i,
    input  logic                mem_rlast_i,
    input  logic                mem_rvalid_i,
    output logic                mem_rready_o,
    input  logic                miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]   miss_addr_fifo_rdata_i,
    output logic                miss_addr_fifo_rden_o,
    output logic                wren_o,
    output logic [INDEX_W-1:0]  waddr_o,
    output logic [TAG_W:0]      wdata_tag_o,
    output logic [LINE_W-1:0]   wdata_data_o,
    output logic                fill_done_o,
    output logic                fill_err_o
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, WRITE} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [PTR_W-1:0]   start_ptr_reg, start_ptr_next;
    logic [PTR_W-1:0]   count_reg, count_next;
    logic               err_reg, err_next;
    logic [LINE_W-1:0]  line_reg, line_next;
    logic               rready_reg, rden_reg, wren_reg, done_reg, ferr_reg;
    logic               rready_next, rden_next, wren_next, done_next, ferr_next;
    logic [INDEX_W-1:0] waddr_reg;
    logic [TAG_W:0]     wtag_reg;
    logic [LINE_W-1:0]  wdata_reg;

    logic               beat_acc;
    logic               fill_we;
    logic [PTR_W-1:0]   slot_sel;
    logic               go_write;

    assign beat_acc = mem_rvalid_i & rready_reg;
    assign fill_we  = (state_reg == FILL) & beat_acc;
    assign slot_sel = start_ptr_reg + count_reg;

    // rresp[0] (exclusive-okay) and the in-beat byte offset carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{mem_rresp_i[0], addr_reg[BOFS_W-1:0]};

    // Slot k lives at the top end of the line; beats land wrapped from start_ptr
    genvar gi;
    generate
        for (gi = 0; gi < LINE_BEATS; gi++) begin : g_slot
            localparam int HI = LINE_W - 1 - gi * BEAT_W;
            assign line_next[HI -: BEAT_W] = (fill_we && slot_sel == PTR_W'(gi)) ?
                                             mem_rdata_i : line_reg[HI -: BEAT_W];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        start_ptr_next = start_ptr_reg;
        count_next     = count_reg;
        err_next       = err_reg;
        case (state_reg)
            IDLE: begin
                if (!miss_addr_fifo_empty_i) begin
                    addr_next      = miss_addr_fifo_rdata_i;
                    start_ptr_next = miss_addr_fifo_rdata_i[OFS_W-1:BOFS_W];
                    count_next     = '0;
                    err_next       = 1'b0;
                    state_next     = FILL;
                end
            end
            FILL: begin
                if (beat_acc) begin
                    count_next = count_reg + 1'b1;
                    if (mem_rresp_i[1]) err_next = 1'b1;
                    if (mem_rlast_i) begin
                        if (count_reg != PTR_W'(LINE_BEATS - 1)) err_next = 1'b1;
                        state_next = WRITE;
                    end else if (count_reg == PTR_W'(LINE_BEATS - 1)) begin
                        err_next   = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat_acc) begin
                    if (mem_rresp_i[1]) err_next = 1'b1;
                    if (mem_rlast_i) state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they are all register-driven
    always_comb begin
        go_write    = (state_reg != WRITE) && (state_next == WRITE);
        rready_next = (state_next == FILL) || (state_next == DRAIN);
        rden_next   = go_write;
        wren_next   = go_write & ~err_next;
        done_next   = go_write & ~err_next;
        ferr_next   = go_write & err_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            start_ptr_reg <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            rready_reg    <= 1'b0;
            rden_reg      <= 1'b0;
            wren_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            waddr_reg     <= '0;
            wtag_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            start_ptr_reg <= start_ptr_next;
            count_reg     <= count_next;
            err_reg       <= err_next;
            rready_reg    <= rready_next;
            rden_reg      <= rden_next;
            wren_reg      <= wren_next;
            done_reg      <= done_next;
            ferr_reg      <= ferr_next;
            if (wren_next) begin
                waddr_reg <= addr_reg[OFS_W +: INDEX_W];
                wtag_reg  <= {1'b1, addr_reg[ADDR_W-1 -: TAG_W]};
                wdata_reg <= line_next;
            end
        end
    end

    // Line buffer contents are don't-care between fills, so it carries no reset
    always_ff @(posedge clk) begin
        line_reg <= line_next;
    end

    assign mem_rready_o          = rready_reg;
    assign miss_addr_fifo_rden_o = rden_reg;
    assign wren_o                = wren_reg;
    assign waddr_o               = waddr_reg;
    assign wdata_tag_o           = wtag_reg;
    assign wdata_data_o          = wdata_reg;
    assign fill_done_o           = done_reg;
    assign fill_err_o            = ferr_reg;

endmodule

// File: tb/tb_cc_line_fill_engine.sv
// Self-checking bench for cc_line_fill_engine: directed vector table, reset corner
// sequence and randomized bursts checked against a line-level reference model.
module tb_cc_line_fill_engine;

    localparam int LB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   mem_rdata;
    logic [1:0]    mem_rresp;
    logic          mem_rlast;
    logic          mem_rvalid;
    logic          mem_rready;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic          fifo_rden;
    logic          wren;
    logic [8:0]    waddr;
    logic [17:0]   wtag;
    logic [511:0]  wdata;
    logic          fill_done;
    logic          fill_err;

    always #5 clk = ~clk;

    cc_line_fill_engine dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_rdata_i            (mem_rdata),
        .mem_rresp_i            (mem_rresp),
        .mem_rlast_i            (mem_rlast),
        .mem_rvalid_i           (mem_rvalid),
        .mem_rready_o           (mem_rready),
        .miss_addr_fifo_empty_i (fifo_empty),
        .miss_addr_fifo_rdata_i (fifo_rdata),
        .miss_addr_fifo_rden_o  (fifo_rden),
        .wren_o                 (wren),
        .waddr_o                (waddr),
        .wdata_tag_o            (wtag),
        .wdata_data_o           (wdata),
        .fill_done_o            (fill_done),
        .fill_err_o             (fill_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the falling edge
    int   rden_cnt = 0, wren_cnt = 0, done_cnt = 0, ferr_cnt = 0;
    int   pulse_cyc = -1;
    logic cap_rready = 1'b0;
    always @(negedge clk) begin
        if (fifo_rden) begin
            rden_cnt   <= rden_cnt + 1;
            pulse_cyc  <= cyc;
            cap_rready <= mem_rready;
        end
        if (wren)      wren_cnt <= wren_cnt + 1;
        if (fill_done) done_cnt <= done_cnt + 1;
        if (fill_err)  ferr_cnt <= ferr_cnt + 1;
    end

    // Reference model state: what the SRAM write port should currently be holding
    logic [511:0] good_line;
    logic [8:0]   good_waddr;
    logic [17:0]  good_tag;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [1:0] resp,
                             input logic last, output bit ok);
        bit acc;
        mem_rdata  = d;
        mem_rresp  = resp;
        mem_rlast  = last;
        mem_rvalid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            acc = mem_rready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    task automatic run_fill(input string name, input logic [31:0] addr, input int nb,
                            input int err_beat, input int gap_max, input int fifo_delay,
                            input bit use_tab, input bit tab_ok,
                            input logic [8:0] tab_waddr, input logic [17:0] tab_tag);
        logic [63:0]  beat;
        logic [1:0]   resp;
        logic [511:0] line;
        logic [8:0]   ew;
        logic [17:0]  et;
        bit           exp_err, ok, all_ok, idle_rdy;
        int           start, last_cyc, r0, w0, d0, e0, slot;
        r0 = rden_cnt; w0 = wren_cnt; d0 = done_cnt; e0 = ferr_cnt;
        idle_rdy = 1'b0;
        fifo_empty = 1'b1;
        for (int k = 0; k < fifo_delay; k++) begin
            @(negedge clk);
            if (mem_rready) idle_rdy = 1'b1;
            @(posedge clk);
            #1;
        end
        if (fifo_delay > 0) chk({name, "/idle_rready"}, 512'(idle_rdy), 512'(0));
        fifo_rdata = addr;
        fifo_empty = 1'b0;

        exp_err  = (nb != LB);
        line     = good_line;
        start    = int'((addr >> 3) % 8);
        all_ok   = 1'b1;
        last_cyc = -2;
        for (int i = 0; i < nb; i++) begin
            for (int g = int'($urandom_range(gap_max, 0)); g > 0; g--) begin
                @(posedge clk);
                #1;
            end
            beat = {$urandom, $urandom};
            resp = (i == err_beat) ? 2'b10 : 2'($urandom_range(1, 0));
            if (resp[1]) exp_err = 1'b1;
            send_beat(beat, resp, (i == nb - 1), ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
            last_cyc = cyc;
            if (i < LB) begin
                slot = (start + i) % LB;
                line[511 - 64 * slot -: 64] = beat;
            end
        end
        @(posedge clk);
        #1;
        fifo_empty = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        if (use_tab) exp_err = !tab_ok;
        if (!exp_err) begin
            good_waddr = 9'((addr >> 6) % 512);
            good_tag   = 18'((addr >> 15) | (32'd1 << 17));
            good_line  = line;
        end
        ew = use_tab ? tab_waddr : good_waddr;
        et = use_tab ? tab_tag   : good_tag;

        $display("fill %s addr=%08h beats=%0d err_beat=%0d expect_err=%0d", name, addr, nb,
                 err_beat, exp_err);
        chk({name, "/handshakes"}, 512'(all_ok), 512'(1));
        chk({name, "/rden_pulses"}, 512'(rden_cnt - r0), 512'(1));
        chk({name, "/wren_pulses"}, 512'(wren_cnt - w0), 512'(!exp_err));
        chk({name, "/done_pulses"}, 512'(done_cnt - d0), 512'(!exp_err));
        chk({name, "/err_pulses"}, 512'(ferr_cnt - e0), 512'(exp_err));
        chk({name, "/pulse_cycle"}, 512'(pulse_cyc), 512'(last_cyc));
        chk({name, "/rready_in_write"}, 512'(cap_rready), 512'(0));
        chk({name, "/waddr"}, 512'(waddr), 512'(ew));
        chk({name, "/wtag"}, 512'(wtag), 512'(et));
        chk({name, "/wdata"}, wdata, good_line);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          nbeats;
        int          err_beat;
        int          gap_max;
        int          fifo_delay;
        bit          exp_ok;
        logic [8:0]  exp_waddr;
        logic [17:0] exp_tag;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit   ok;
        int   r0, w0;
        int   nb, eb, rr;

        vecs[0] = '{32'h0001_2340,  8, -1, 0, 0, 1'b1, 9'h08D, 18'h20002};
        vecs[1] = '{32'h0000_0028,  8, -1, 0, 0, 1'b1, 9'h000, 18'h20000};
        vecs[2] = '{32'h0001_2340,  8,  3, 0, 0, 1'b0, 9'h000, 18'h20000};
        vecs[3] = '{32'h0001_2340,  4, -1, 0, 0, 1'b0, 9'h000, 18'h20000};
        vecs[4] = '{32'h0001_2340, 10, -1, 0, 0, 1'b0, 9'h000, 18'h20000};
        vecs[5] = '{32'h0001_2340,  8, -1, 3, 4, 1'b1, 9'h08D, 18'h20002};

        rst_n = 1'b0; mem_rdata = '0; mem_rresp = '0; mem_rlast = 1'b0; mem_rvalid = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = '0;
        good_line = '0; good_waddr = '0; good_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset/rready", 512'(mem_rready), 512'(0));
        chk("reset/pulses", 512'({fifo_rden, wren, fill_done, fill_err}), 512'(0));
        chk("reset/waddr_tag", 512'({waddr, wtag}), 512'(0));
        chk("reset/wdata", wdata, 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        for (int v = 0; v < 6; v++)
            run_fill($sformatf("vec%0d", v), vecs[v].addr, vecs[v].nbeats, vecs[v].err_beat,
                     vecs[v].gap_max, vecs[v].fifo_delay, 1'b1, vecs[v].exp_ok,
                     vecs[v].exp_waddr, vecs[v].exp_tag);

        // Reset in the middle of a burst: nothing may be written or popped
        r0 = rden_cnt; w0 = wren_cnt;
        fifo_rdata = 32'h0001_2340;
        fifo_empty = 1'b0;
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 2'b00, 1'b0, ok);
        rst_n = 1'b0;
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst/rready", 512'(mem_rready), 512'(0));
        chk("midrst/pulses", 512'({fifo_rden, wren, fill_done, fill_err}), 512'(0));
        chk("midrst/waddr_tag", 512'({waddr, wtag}), 512'(0));
        chk("midrst/wdata", wdata, 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        good_line = '0; good_waddr = '0; good_tag = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midrst/no_rden", 512'(rden_cnt - r0), 512'(0));
        chk("midrst/no_wren", 512'(wren_cnt - w0), 512'(0));
        run_fill("post_reset", vecs[0].addr, 8, -1, 0, 0, 1'b1, 1'b1, 9'h08D, 18'h20002);

        for (int t = 0; t < 24; t++) begin
            rr = int'($urandom_range(9, 0));
            if (rr < 7)       nb = LB;
            else if (rr == 7) nb = int'($urandom_range(7, 1));
            else              nb = int'($urandom_range(12, 9));
            eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
            run_fill($sformatf("rand%0d", t), $urandom, nb, eb, 3,
                     int'($urandom_range(2, 0)), 1'b0, 1'b0, 9'h000, 18'h00000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
